// File: rtl/dmem_apb_arbiter.sv
// Two-port (D = load/store unit, F = fetch unit) arbiter onto one APB data-memory master.
// D has fixed priority; a bounded D streak guarantees F forward progress.
module dmem_apb_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DAT_W        = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_req_valid,
  input  logic                d_req_write,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DAT_W-1:0]    d_req_wdata,
  input  logic [DAT_W/8-1:0]  d_req_strb,
  output logic                d_gnt,
  output logic                d_rsp_valid,
  output logic [DAT_W-1:0]    d_rsp_rdata,
  output logic                d_rsp_err,
  input  logic                f_req_valid,
  input  logic                f_req_write,
  input  logic [ADDR_W-1:0]   f_req_addr,
  input  logic [DAT_W-1:0]    f_req_wdata,
  input  logic [DAT_W/8-1:0]  f_req_strb,
  output logic                f_gnt,
  output logic                f_rsp_valid,
  output logic [DAT_W-1:0]    f_rsp_rdata,
  output logic                f_rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DAT_W-1:0]    pwdata,
  output logic [DAT_W/8-1:0]  pstrb,
  input  logic                pready,
  input  logic [DAT_W-1:0]    prdata,
  input  logic                pslverr,
  output logic                busy
);

  localparam int unsigned StrbW   = DAT_W / 8;
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e               state_q, state_d;
  logic                 hold_write_q;
  logic [ADDR_W-1:0]    hold_addr_q;
  logic [DAT_W-1:0]     hold_wdata_q;
  logic [StrbW-1:0]     hold_strb_q;
  logic                 owner_q;  // 0 = D, 1 = F
  logic [StreakW-1:0]   streak_q, streak_d;
  logic [DAT_W-1:0]     d_rdata_q, f_rdata_q;
  logic                 d_err_q, f_err_q;

  logic done, arb, pick_f;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    done     = (state_q == StAccess) && pready;
    // Gated by rst so no grant can escape while the block is held in reset.
    arb      = !rst && ((state_q == StIdle) || done);
    pick_f   = f_req_valid && (!d_req_valid || (streak_q == StreakMax));
    d_gnt    = arb && d_req_valid && !pick_f;
    f_gnt    = arb && pick_f;

    unique case (state_q)
      StIdle:   if (d_gnt || f_gnt) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready) state_d = (d_gnt || f_gnt) ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase

    if (!f_req_valid || f_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    psel        = (state_q != StIdle);
    penable     = (state_q == StAccess);
    busy        = (state_q != StIdle);
    pwrite      = hold_write_q;
    paddr       = hold_addr_q;
    pwdata      = hold_wdata_q;
    pstrb       = hold_strb_q;
    d_rsp_valid = done && !owner_q;
    f_rsp_valid = done && owner_q;
    d_rsp_rdata = d_rsp_valid ? prdata  : d_rdata_q;
    d_rsp_err   = d_rsp_valid ? pslverr : d_err_q;
    f_rsp_rdata = f_rsp_valid ? prdata  : f_rdata_q;
    f_rsp_err   = f_rsp_valid ? pslverr : f_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      streak_q     <= '0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_strb_q  <= '0;
      owner_q      <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      f_err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (d_gnt) begin
        hold_write_q <= d_req_write;
        hold_addr_q  <= d_req_addr;
        hold_wdata_q <= d_req_wdata;
        hold_strb_q  <= d_req_strb;
        owner_q      <= 1'b0;
      end else if (f_gnt) begin
        hold_write_q <= f_req_write;
        hold_addr_q  <= f_req_addr;
        hold_wdata_q <= f_req_wdata;
        hold_strb_q  <= f_req_strb;
        owner_q      <= 1'b1;
      end
      if (d_rsp_valid) begin
        d_rdata_q <= prdata;
        d_err_q   <= pslverr;
      end
      if (f_rsp_valid) begin
        f_rdata_q <= prdata;
        f_err_q   <= pslverr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// Bench for dmem_apb_arbiter: transaction-level model checked every cycle plus directed
// scenarios with literal expectations.
module tb_dmem_apb_arbiter;

  localparam int unsigned MaxStreak = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_req_valid = 0, d_req_write = 0;
  logic [31:0] d_req_addr = 0, d_req_wdata = 0;
  logic [3:0]  d_req_strb = 0;
  logic        f_req_valid = 0, f_req_write = 0;
  logic [31:0] f_req_addr = 0, f_req_wdata = 0;
  logic [3:0]  f_req_strb = 0;
  logic        pready = 0, pslverr = 0;
  logic [31:0] prdata = 0;
  logic        d_gnt, d_rsp_valid, d_rsp_err, f_gnt, f_rsp_valid, f_rsp_err;
  logic [31:0] d_rsp_rdata, f_rsp_rdata, paddr, pwdata;
  logic        psel, penable, pwrite, busy;
  logic [3:0]  pstrb;

  int checks = 0;
  int errors = 0;

  dmem_apb_arbiter #(.ADDR_W(32), .DAT_W(32), .MAX_D_STREAK(MaxStreak)) dut (
    .clk(clk), .rst(rst),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb), .d_gnt(d_gnt),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .f_req_valid(f_req_valid), .f_req_write(f_req_write), .f_req_addr(f_req_addr),
    .f_req_wdata(f_req_wdata), .f_req_strb(f_req_strb), .f_gnt(f_gnt),
    .f_rsp_valid(f_rsp_valid), .f_rsp_rdata(f_rsp_rdata), .f_rsp_err(f_rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one in-flight transfer with its age in cycles since grant.
  logic        m_busy, m_owner_f, m_write;
  int          m_age, m_streak;
  logic [31:0] m_addr, m_wdata, m_d_rdata, m_f_rdata;
  logic [3:0]  m_strb;
  logic        m_d_err, m_f_err;
  logic        m_done, m_arb, m_take_f, m_take_d, m_d_fin, m_f_fin;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_owner_f = 0; m_streak = 0;
      m_d_rdata = 0; m_f_rdata = 0; m_d_err = 0; m_f_err = 0;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {d_gnt, f_gnt}, 0);
      chk("rst_rspv", {d_rsp_valid, f_rsp_valid}, 0);
      chk("rst_rdata", {d_rsp_rdata, f_rsp_rdata}, 0);
    end else begin
      m_done   = m_busy && (m_age >= 1) && pready;
      m_arb    = !m_busy || m_done;
      m_take_f = m_arb && f_req_valid && (!d_req_valid || (m_streak == MaxStreak));
      m_take_d = m_arb && d_req_valid && !m_take_f;
      m_d_fin  = m_done && !m_owner_f;
      m_f_fin  = m_done && m_owner_f;
      chk("m_psel", psel, m_busy);
      chk("m_penable", penable, m_busy && (m_age >= 1));
      chk("m_busy", busy, m_busy);
      chk("m_d_gnt", d_gnt, m_take_d);
      chk("m_f_gnt", f_gnt, m_take_f);
      chk("m_d_rspv", d_rsp_valid, m_d_fin);
      chk("m_f_rspv", f_rsp_valid, m_f_fin);
      chk("m_d_rdata", d_rsp_rdata, m_d_fin ? prdata : m_d_rdata);
      chk("m_d_err", d_rsp_err, m_d_fin ? pslverr : m_d_err);
      chk("m_f_rdata", f_rsp_rdata, m_f_fin ? prdata : m_f_rdata);
      chk("m_f_err", f_rsp_err, m_f_fin ? pslverr : m_f_err);
      if (m_busy) chk("m_apb_fields", {pwrite, paddr, pwdata, pstrb},
                      {m_write, m_addr, m_wdata, m_strb});
      if (m_d_fin) begin m_d_rdata = prdata; m_d_err = pslverr; end
      if (m_f_fin) begin m_f_rdata = prdata; m_f_err = pslverr; end
      if (m_take_d || m_take_f) begin
        m_busy = 1; m_age = 0; m_owner_f = m_take_f;
        m_write = m_take_f ? f_req_write : d_req_write;
        m_addr  = m_take_f ? f_req_addr  : d_req_addr;
        m_wdata = m_take_f ? f_req_wdata : d_req_wdata;
        m_strb  = m_take_f ? f_req_strb  : d_req_strb;
      end else if (m_done) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_age++;
      end
      if (!f_req_valid || m_take_f) m_streak = 0;
      else if (m_take_d && m_streak < MaxStreak) m_streak++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic exp_f [10];

  initial begin
    exp_f = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    step(); step();
    rst = 0;
    mid();
    chk("reset_idle", {psel, penable, busy}, 0);

    // D load, immediate pready
    step();
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h100; pready = 1; prdata = 32'hDEADBEEF;
    mid(); chk("t1_gnt", d_gnt, 1); chk("t1_nopsel", psel, 0);
    step(); d_req_valid = 0;
    mid(); chk("t1_setup", {psel, penable}, 2'b10); chk("t1_paddr", paddr, 32'h100);
    step();
    mid(); chk("t1_access", {psel, penable, d_rsp_valid}, 3'b111);
    chk("t1_rdata", d_rsp_rdata, 32'hDEADBEEF);
    step();
    mid(); chk("t1_idle", {busy, d_rsp_valid}, 0); chk("t1_hold", d_rsp_rdata, 32'hDEADBEEF);

    // F store with three wait states
    step();
    f_req_valid = 1; f_req_write = 1; f_req_addr = 32'h40; f_req_wdata = 32'h12345678;
    f_req_strb = 4'hF; pready = 0; prdata = 0;
    mid(); chk("t2_gnt", f_gnt, 1);
    step(); f_req_valid = 0;
    mid(); chk("t2_setup", {psel, penable, pwrite}, 3'b101);
    for (int i = 0; i < 4; i++) begin
      step(); pready = (i == 3);
      mid();
      chk("t2_fields", {penable, pwrite, paddr, pwdata}, {2'b11, 32'h40, 32'h12345678});
      chk("t2_rspv", f_rsp_valid, (i == 3));
    end
    step(); pready = 0;
    mid(); chk("t2_idle", busy, 0);

    // Both requesters saturating: streak limit forces every fifth grant to F
    step();
    d_req_valid = 1; f_req_valid = 1; d_req_write = 0; f_req_write = 0;
    d_req_addr = 32'h1000; f_req_addr = 32'h2000; pready = 1;
    mid();
    for (int k = 0; k < 10; k++) begin
      chk("t3_order_f", f_gnt, exp_f[k]);
      chk("t3_order_d", d_gnt, !exp_f[k]);
      step();
      if (exp_f[k]) f_req_addr += 4; else d_req_addr += 4;
      if (k == 9) begin d_req_valid = 0; f_req_valid = 0; end
      prdata = 32'hA000_0000 + k;
      mid(); chk("t3_psel_setup", psel, 1);
      step();
      mid(); chk("t3_psel_access", {psel, penable}, 2'b11);
    end
    chk("t3_no_more_gnt", {d_gnt, f_gnt}, 0);
    step();
    mid(); chk("t3_idle", busy, 0);

    // D store with slave error, back-to-back D load without error
    step();
    d_req_valid = 1; d_req_write = 1; d_req_addr = 32'h200; d_req_wdata = 32'h55AA55AA;
    d_req_strb = 4'b0011; pslverr = 1; prdata = 32'h0;
    mid(); chk("t4_gnt", d_gnt, 1);
    step(); d_req_valid = 0;
    mid(); chk("t4_setup", {psel, penable}, 2'b10);
    step(); d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h204;
    mid(); chk("t4_err", {d_rsp_valid, d_rsp_err}, 2'b11);
    chk("t6_b2b_gnt", d_gnt, 1);
    step(); d_req_valid = 0; pslverr = 0; prdata = 32'h0BADF00D;
    mid(); chk("t6_setup", {psel, penable}, 2'b10); chk("t6_paddr", paddr, 32'h204);
    chk("t4_err_held", d_rsp_err, 1);
    step();
    mid(); chk("t4_noerr", {d_rsp_valid, d_rsp_err}, 2'b10);
    chk("t6_rdata", d_rsp_rdata, 32'h0BADF00D);
    step();
    mid(); chk("t4_idle", busy, 0);

    // Reset in the middle of a stalled access
    step();
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h300; pready = 0;
    mid(); chk("t5_gnt", d_gnt, 1);
    step(); d_req_valid = 0;
    mid(); chk("t5_setup", psel, 1);
    step();
    mid(); chk("t5_access", penable, 1);
    step(); #2; rst = 1; #1;
    chk("t5_abort", {psel, penable, busy, d_rsp_valid}, 0);
    chk("t5_rdata_clr", d_rsp_rdata, 0);
    step(); rst = 0;
    mid(); chk("t5_post_idle", busy, 0);
    step();
    d_req_valid = 1; d_req_addr = 32'h304; prdata = 32'hCAFEF00D; pready = 1;
    mid(); chk("t5_gnt2", d_gnt, 1);
    step(); d_req_valid = 0;
    mid(); chk("t5_setup2", {psel, penable}, 2'b10);
    step();
    mid(); chk("t5_rsp2", d_rsp_valid, 1); chk("t5_rdata2", d_rsp_rdata, 32'hCAFEF00D);
    step();
    mid(); chk("t5_idle2", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_apb_arbiter.md
Name: dmem_apb_arbiter

Overview:
- Shares the single data-memory APB master port between two requesters.
- Port D is the exe/mem/wb load-store unit; port F is the instruction-fetch unit.
- Sequences the APB SETUP/ACCESS phases and supports back-to-back transfers.
- Uses fixed D-over-F priority with a streak limit so F cannot starve.

Parameters:
ADDR_W, 32, address width of requests and paddr
DAT_W, 32, data width of wdata/rdata/pwdata/prdata
MAX_D_STREAK, 4, max consecutive D grants while F waits (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
d_req_valid  in  1  D request; held with fields stable until d_gnt
d_req_write  in  1  1=store, 0=load
d_req_addr  in  ADDR_W  D address
d_req_wdata  in  DAT_W  D store data
d_req_strb  in  DAT_W/8  D byte strobes
d_gnt  out  1  one-cycle pulse: D request latched
d_rsp_valid  out  1  one-cycle pulse: D transfer complete
d_rsp_rdata  out  DAT_W  prdata captured at completion
d_rsp_err  out  1  pslverr captured at completion
f_req_valid, f_req_write, f_req_addr, f_req_wdata, f_req_strb  in  (as D)  F request
f_gnt, f_rsp_valid, f_rsp_rdata, f_rsp_err  out  (as D)  F handshake/response
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DAT_W  APB write data
pstrb  out  DAT_W/8  APB strobes
pready  in  1  APB ready
prdata  in  DAT_W  APB read data
pslverr  in  1  APB error
busy  out  1  transfer in flight (state != IDLE)

Behaviour:
- Reset (async, immediate): state IDLE; psel, penable, gnt, rsp_valid, busy all 0; rsp data/err 0; holding regs 0; owner=D; streak=0. Reset mid-transfer aborts it: psel/penable drop, no rsp issued.
- States: IDLE, SETUP, ACCESS.
- Arbitration point = IDLE, or ACCESS with pready=1. At this point:
  - If any req_valid: pick winner, latch write/addr/wdata/strb/owner into holding regs, pulse winner's gnt in the same cycle, next state SETUP.
  - Otherwise next state IDLE.
- SETUP: psel=1, penable=0, next ACCESS unconditionally.
- ACCESS: psel=1, penable=1. Stays while pready=0. On pready=1:
  - owner's rsp_valid=1 that cycle; rsp_rdata=prdata, rsp_err=pslverr (combinational pass, registered copies held afterwards).
  - Arbitration for the next transfer happens in this same cycle, giving gap-free SETUP.
- APB outputs are driven only from the holding regs; they are stable from SETUP through ACCESS completion. pwdata/pstrb are driven for reads too; slaves ignore them.
- Winner select:
  - Only one valid: that one wins.
  - Both valid: D wins unless streak == MAX_D_STREAK, in which case F wins.
- Streak counter:
  - +1 on a D grant while f_req_valid=1 (saturates at MAX_D_STREAK).
  - Cleared on any F grant, or in any cycle f_req_valid=0.
- Latency: request in IDLE -> gnt same cycle; psel next cycle; earliest rsp_valid 2 cycles after gnt (pready=1 in first ACCESS cycle). Back-to-back throughput is 1 transfer per 2 cycles.
- Single outstanding transfer total. A requester may reassert req_valid in its own rsp_valid cycle; that request is eligible in that same cycle.
- pslverr/prdata are ignored when pready=0 or outside ACCESS.
- rsp_rdata/rsp_err of the non-owner port hold their previous values.
- gnt and rsp_valid are never asserted for both ports in the same cycle for gnt. A port may see rsp_valid and gnt together (back-to-back).

Test Plan:
- D load only, addr=0x100, pready=1 immediately, prdata=0xDEADBEEF -> d_gnt cycle0; psel=1/penable=0 cycle1; penable=1 cycle2 with d_rsp_valid=1, d_rsp_rdata=0xDEADBEEF; IDLE cycle3.
- F store, addr=0x40, wdata=0x12345678, strb=0xF, pready low 3 ACCESS cycles -> paddr/pwdata/pwrite=1 stable through wait states; f_rsp_valid exactly once, on the 4th ACCESS cycle.
- D and F held valid continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; psel never deasserts between transfers.
- pslverr=1 with pready=1 on D store -> d_rsp_err=1 for that pulse; next transfer with pslverr=0 -> d_rsp_err=0.
- rst asserted during ACCESS with pready=0 -> psel/penable/busy=0 immediately, no rsp_valid; after release, a new D request completes normally.
- Back-to-back: D reasserts req in its d_rsp_valid cycle, F idle -> d_gnt coincides with d_rsp_valid, SETUP the next cycle.
